// File: rtl/subleq_ctrl_pkg.sv
// Shared definitions for the SUBLEQ sequencer: state encoding, instruction
// geometry, default entry/exit addresses and the branch rule.
package subleq_ctrl_pkg;

    localparam int         INSN_BYTES   = 3;
    localparam logic [7:0] DEF_START_PC = 8'd1;
    localparam logic [7:0] DEF_HALT_PC  = 8'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F_A  = 3'd1,
        S_F_B  = 3'd2,
        S_F_C  = 3'd3,
        S_R_A  = 3'd4,
        S_R_B  = 3'd5,
        S_WR   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    // Branch on a zero or negative result. c is a signed offset, but mod-256
    // addition gives the right answer without any sign extension.
    function automatic logic [7:0] next_pc(input logic [7:0] pc,
                                           input logic [7:0] c,
                                           input logic [7:0] diff);
        logic [7:0] fall;
        fall = pc + 8'(INSN_BYTES);
        return (diff[7] || diff == 8'd0) ? fall + c : fall;
    endfunction

endpackage

// File: rtl/subleq_ctrl_if.sv
// Host access port of the SUBLEQ sequencer. The loader is the master and
// the sequencer is the slave.
interface subleq_ctrl_if;

    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata
    );

endinterface

// File: rtl/subleq_port_mux.sv
// Selects between host and core for the single memory port. The host is
// granted only while the core is parked and no start is being issued.
module subleq_port_mux (
    input  logic       core_idle,
    input  logic       start,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    input  logic       core_we,
    output logic       host_gnt,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we
);

    assign host_gnt = host_req & core_idle & ~start;

    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end
    end

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencer: fetches A,B,C, performs mem[B] -= mem[A] and branches on
// a non-positive result. Six cycles per instruction over one memory port.
module subleq_ctrl
    import subleq_ctrl_pkg::*;
#(
    parameter logic [7:0] START_PC = DEF_START_PC,
    parameter logic [7:0] HALT_PC  = DEF_HALT_PC,
    parameter int         ICNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        pc,
    output logic [ICNT_W-1:0] icnt,
    output logic [7:0]        mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    subleq_ctrl_if.slave      host
);

    state_t     state_q, state_d;
    logic [7:0] a, b, c, va, diff;
    logic [7:0] pc_next;
    logic [7:0] core_addr;
    logic       core_we;
    logic       core_idle;

    assign core_idle = (state_q == S_IDLE) || (state_q == S_HALT);
    assign busy      = ~core_idle;
    assign halted    = (state_q == S_HALT);
    assign pc_next   = next_pc(pc, c, diff);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        core_addr = pc;
        core_we   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_F_A;
            S_F_A: state_d = S_F_B;
            S_F_B: begin
                core_addr = pc + 8'd1;
                state_d   = S_F_C;
            end
            S_F_C: begin
                core_addr = pc + 8'd2;
                state_d   = S_R_A;
            end
            S_R_A: begin
                core_addr = a;
                state_d   = S_R_B;
            end
            S_R_B: begin
                core_addr = b;
                state_d   = S_WR;
            end
            S_WR: begin
                core_addr = b;
                core_we   = 1'b1;
                state_d   = (pc_next == HALT_PC) ? S_HALT : S_F_A;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= START_PC;
            icnt <= '0;
            a    <= '0;
            b    <= '0;
            c    <= '0;
            va   <= '0;
            diff <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc   <= START_PC;
                        icnt <= '0;
                    end
                end
                S_F_A: a  <= mem_rdata;
                S_F_B: b  <= mem_rdata;
                S_F_C: c  <= mem_rdata;
                S_R_A: va <= mem_rdata;
                S_R_B: diff <= mem_rdata - va;
                S_WR: begin
                    pc <= pc_next;
                    if (icnt != '1) icnt <= icnt + ICNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    subleq_port_mux u_port_mux (
        .core_idle  (core_idle),
        .start      (start),
        .host_req   (host.host_req),
        .host_we    (host.host_we),
        .host_addr  (host.host_addr),
        .host_wdata (host.host_wdata),
        .core_addr  (core_addr),
        .core_wdata (diff),
        .core_we    (core_we),
        .host_gnt   (host.host_gnt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we)
    );

    assign host.host_rdata = mem_rdata;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Self-checking bench for subleq_ctrl: 256x8 memory model, an instruction-level
// SUBLEQ reference model, directed scenarios and randomized programs.
module tb_subleq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, halted, mem_we;
    logic [7:0]  pc, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] icnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    logic [8:0] got_trace[$];
    logic [8:0] exp_trace[$];
    logic [7:0] got_pcs[$];
    bit         rec_en = 1'b0;

    subleq_ctrl_if host_if ();

    subleq_ctrl #(.START_PC(8'd1), .HALT_PC(8'd0), .ICNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .icnt      (icnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .host      (host_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) begin
        if (rec_en) begin
            if (busy) got_trace.push_back({mem_we, mem_addr});
            if ((busy || halted) && (got_pcs.size() == 0 || got_pcs[$] != pc))
                got_pcs.push_back(pc);
        end
    end

    // Instruction-level reference: executes SUBLEQ on ref_mem and lists the
    // memory accesses each instruction must make (fetch x3, read A, read B, write B).
    task automatic model_run(input logic [7:0] start_pc, input int max_insns,
                             output int n, output logic [7:0] pc_o, output bit halt_o);
        logic [7:0] p, p1, p2, ia, ib, ic, d;
        p = start_pc; n = 0; halt_o = 1'b0;
        exp_trace.delete();
        while (n < max_insns && !halt_o) begin
            p1 = p + 8'd1;
            p2 = p + 8'd2;
            ia = ref_mem[p]; ib = ref_mem[p1]; ic = ref_mem[p2];
            d  = ref_mem[ib] - ref_mem[ia];
            exp_trace.push_back({1'b0, p});
            exp_trace.push_back({1'b0, p1});
            exp_trace.push_back({1'b0, p2});
            exp_trace.push_back({1'b0, ia});
            exp_trace.push_back({1'b0, ib});
            exp_trace.push_back({1'b1, ib});
            ref_mem[ib] = d;
            if ($signed(d) <= 0) p = p + 8'd3 + ic;
            else                 p = p + 8'd3;
            n++;
            if (p == 8'd0) halt_o = 1'b1;
        end
        pc_o = p;
    endtask

    function automatic int mem_diffs();
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        return bad;
    endfunction

    function automatic int trace_diffs();
        int bad = 0;
        if (got_trace.size() != exp_trace.size()) return 1000;
        foreach (exp_trace[i]) if (got_trace[i] !== exp_trace[i]) bad++;
        return bad;
    endfunction

    // Quotient-by-subtraction program: X@16, Y@17, -count@18, Q@19, ONE@20.
    task automatic set_base_image();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        ref_mem[1]  = 8'd17; ref_mem[2]  = 8'd16; ref_mem[3]  = 8'd3;
        ref_mem[4]  = 8'd20; ref_mem[5]  = 8'd18; ref_mem[6]  = 8'hFA;
        ref_mem[7]  = 8'd18; ref_mem[8]  = 8'd19; ref_mem[9]  = 8'd0;
        ref_mem[10] = 8'd20; ref_mem[11] = 8'd0;  ref_mem[12] = 8'hF3;
        ref_mem[16] = 8'd24; ref_mem[17] = 8'd7;  ref_mem[20] = 8'd1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; start = 1'b0; rec_en = 1'b0;
        host_if.host_req = 1'b0; host_if.host_we = 1'b0;
        host_if.host_addr = 8'd0; host_if.host_wdata = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic host_write(input logic [7:0] addr, input logic [7:0] data);
        host_if.host_req = 1'b1; host_if.host_we = 1'b1;
        host_if.host_addr = addr; host_if.host_wdata = data;
        @(posedge clk); #1;
        host_if.host_req = 1'b0; host_if.host_we = 1'b0;
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) host_write(8'(i), ref_mem[i]);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_trace.delete(); got_pcs.delete();
        rec_en = 1'b1;
    endtask

    task automatic run_core(input int max_cycles, input bit noisy, output int busy_cycles,
                            output int leaks, output bit saw_halt);
        busy_cycles = 0; leaks = 0; saw_halt = 1'b0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (noisy) begin
                host_if.host_req   = 1'($urandom);
                host_if.host_we    = 1'b1;
                host_if.host_addr  = 8'($urandom);
                host_if.host_wdata = 8'($urandom);
            end
            @(negedge clk);
            if (halted) begin
                saw_halt = 1'b1;
                host_if.host_req = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            if (host_if.host_gnt) leaks++;
            @(posedge clk); #1;
        end
        host_if.host_req = 1'b0; host_if.host_we = 1'b0;
        if (saw_halt) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (pc !== 8'd1) begin miscompares++; $display("FAIL reset_pc: got %0d want 1", pc); end
        vectors++; if (icnt !== 16'd0) begin miscompares++; $display("FAIL reset_icnt: got %0d want 0", icnt); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 8'd1) begin miscompares++; $display("FAIL reset_addr: got %0d want 1", mem_addr); end
        host_if.host_req = 1'b1; host_if.host_addr = 8'h5A; #1;
        vectors++; if (host_if.host_gnt !== 1'b1) begin miscompares++; $display("FAIL idle_gnt: got %b want 1", host_if.host_gnt); end
        vectors++; if (mem_addr !== 8'h5A) begin miscompares++; $display("FAIL idle_host_addr: got %0h want 5a", mem_addr); end
        host_if.host_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_program();
        int n, bc, lk; logic [7:0] mpc; bit mh, sh;
        set_base_image();
        load_image();
        model_run(8'd1, 50, n, mpc, mh);
        start_run();
        run_core(200, 1'b0, bc, lk, sh);
        rec_en = 1'b0;
        vectors++; if (!sh) begin miscompares++; $display("FAIL prog_timeout: halted never rose"); end
        vectors++; if (bc != 54) begin miscompares++; $display("FAIL prog_busy_cycles: got %0d want 54", bc); end
        vectors++; if (icnt !== 16'd9) begin miscompares++; $display("FAIL prog_icnt: got %0d want 9", icnt); end
        vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL prog_pc: got %0d want 0", pc); end
        vectors++; if (mem[19] !== 8'd3) begin miscompares++; $display("FAIL prog_mem19: got %0h want 3", mem[19]); end
        vectors++; if (mem[16] !== 8'hFC) begin miscompares++; $display("FAIL prog_mem16: got %0h want fc", mem[16]); end
        vectors++; if (mem[18] !== 8'hFD) begin miscompares++; $display("FAIL prog_mem18: got %0h want fd", mem[18]); end
        vectors++; if (mem[0] !== 8'hFF) begin miscompares++; $display("FAIL prog_mem0: got %0h want ff", mem[0]); end
        vectors++; if (mem_diffs() != 0) begin miscompares++; $display("FAIL prog_mem_image: %0d bytes differ from model, want 0", mem_diffs()); end
        vectors++; if (trace_diffs() != 0) begin miscompares++; $display("FAIL prog_bus_trace: %0d entries differ (got %0d, want %0d)", trace_diffs(), got_trace.size(), exp_trace.size()); end
    endtask

    task automatic test_host_branch();
        int n, bc, lk; logic [7:0] mpc; bit mh, sh;
        logic [7:0] want_pcs [4];
        want_pcs[0] = 8'd1; want_pcs[1] = 8'd7; want_pcs[2] = 8'd10; want_pcs[3] = 8'd0;
        set_base_image();
        load_image();
        host_write(8'd16, 8'd7);
        host_write(8'd17, 8'd7);
        ref_mem[16] = 8'd7; ref_mem[17] = 8'd7;
        model_run(8'd1, 50, n, mpc, mh);
        start_run();
        run_core(200, 1'b0, bc, lk, sh);
        rec_en = 1'b0;
        vectors++; if (!sh) begin miscompares++; $display("FAIL branch_timeout: halted never rose"); end
        vectors++;
        if (got_pcs.size() != 4) begin
            miscompares++; $display("FAIL branch_pc_trace_len: got %0d want 4", got_pcs.size());
        end else begin
            for (int i = 0; i < 4; i++)
                if (got_pcs[i] !== want_pcs[i]) begin
                    miscompares++; $display("FAIL branch_pc_trace[%0d]: got %0d want %0d", i, got_pcs[i], want_pcs[i]);
                    break;
                end
        end
        vectors++; if (mem[19] !== 8'd0) begin miscompares++; $display("FAIL branch_mem19: got %0h want 0", mem[19]); end
        vectors++; if (icnt !== 16'(n)) begin miscompares++; $display("FAIL branch_icnt: got %0d want %0d", icnt, n); end
        vectors++; if (mem_diffs() != 0) begin miscompares++; $display("FAIL branch_mem_image: %0d bytes differ", mem_diffs()); end
    endtask

    task automatic test_reset_mid();
        set_base_image();
        load_image();
        start_run();
        repeat (11) @(posedge clk);
        #1;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'd18) begin miscompares++; $display("FAIL mid_wr_phase: got we=%b addr=%0d want we=1 addr=18", mem_we, mem_addr); end
        rst_n = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_we: got %b want 0", mem_we); end
        vectors++; if (busy !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL mid_rst_state: got busy=%b halted=%b want 0,0", busy, halted); end
        vectors++; if (pc !== 8'd1) begin miscompares++; $display("FAIL mid_rst_pc: got %0d want 1", pc); end
        vectors++; if (icnt !== 16'd0) begin miscompares++; $display("FAIL mid_rst_icnt: got %0d want 0", icnt); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rec_en = 1'b0;
        vectors++; if (mem[18] !== 8'd0) begin miscompares++; $display("FAIL mid_rst_target: got %0h want 0", mem[18]); end
        vectors++; if (mem[16] !== 8'd17) begin miscompares++; $display("FAIL mid_rst_first_insn: got %0d want 17", mem[16]); end
    endtask

    task automatic test_host_stall();
        int n, leaks, cyc; logic [7:0] mpc; bit mh, sh;
        set_base_image();
        load_image();
        model_run(8'd1, 50, n, mpc, mh);
        start_run();
        @(posedge clk); #1;
        host_if.host_req = 1'b1; host_if.host_we = 1'b0; host_if.host_addr = 8'd19;
        leaks = 0; sh = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (halted) begin sh = 1'b1; break; end
            if (host_if.host_gnt !== 1'b0) leaks++;
        end
        rec_en = 1'b0;
        vectors++; if (!sh) begin miscompares++; $display("FAIL stall_timeout: halted never rose"); end
        vectors++; if (leaks != 0) begin miscompares++; $display("FAIL stall_gnt_while_busy: got %0d grant cycles want 0", leaks); end
        vectors++; if (host_if.host_gnt !== 1'b1) begin miscompares++; $display("FAIL stall_gnt_at_halt: got %b want 1", host_if.host_gnt); end
        vectors++; if (host_if.host_rdata !== 8'd3) begin miscompares++; $display("FAIL stall_host_read19: got %0h want 3", host_if.host_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_host_halt();
        int n, bc, lk; logic [7:0] mpc; bit mh, sh;
        model_run(8'd1, 50, n, mpc, mh);
        host_if.host_req = 1'b1; host_if.host_we = 1'b1;
        host_if.host_addr = 8'd19; host_if.host_wdata = 8'hAA;
        start = 1'b1;
        #1;
        vectors++; if (host_if.host_gnt !== 1'b0) begin miscompares++; $display("FAIL collide_gnt: got %b want 0", host_if.host_gnt); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL collide_we: got %b want 0", mem_we); end
        @(posedge clk); #1;
        start = 1'b0; host_if.host_req = 1'b0; host_if.host_we = 1'b0;
        got_trace.delete(); got_pcs.delete(); rec_en = 1'b1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL collide_busy: got %b want 1", busy); end
        vectors++; if (mem[19] !== 8'd3) begin miscompares++; $display("FAIL collide_no_host_write: got %0h want 3", mem[19]); end
        run_core(200, 1'b0, bc, lk, sh);
        rec_en = 1'b0;
        vectors++; if (!sh || bc != 6 * n) begin miscompares++; $display("FAIL collide_rerun: got halt=%b cycles=%0d want halt=1 cycles=%0d", sh, bc, 6 * n); end
        vectors++; if (mem_diffs() != 0) begin miscompares++; $display("FAIL collide_mem_image: %0d bytes differ", mem_diffs()); end
    endtask

    task automatic test_wrap();
        int n, bc, lk; logic [7:0] mpc; bit mh, sh;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        ref_mem[1]   = 8'd32; ref_mem[2]   = 8'd33; ref_mem[3] = 8'hFA;
        ref_mem[4]   = 8'd32; ref_mem[5]   = 8'd34; ref_mem[6] = 8'hF9;
        ref_mem[254] = 8'd30; ref_mem[255] = 8'd31; ref_mem[0] = 8'h55;
        ref_mem[30]  = 8'd3;  ref_mem[31]  = 8'd10;
        ref_mem[32]  = 8'd1;  ref_mem[33]  = 8'h81;
        load_image();
        model_run(8'd1, 50, n, mpc, mh);
        start_run();
        run_core(200, 1'b0, bc, lk, sh);
        rec_en = 1'b0;
        vectors++; if (!sh) begin miscompares++; $display("FAIL wrap_timeout: halted never rose"); end
        vectors++;
        if (got_trace.size() < 9 || got_trace[6] !== 9'd254 || got_trace[7] !== 9'd255 || got_trace[8] !== 9'd0) begin
            miscompares++; $display("FAIL wrap_fetch_addrs: got %0d entries, want fetches 254,255,0 at entries 6..8", got_trace.size());
        end
        vectors++; if (got_pcs.size() < 3 || got_pcs[2] !== 8'd1) begin miscompares++; $display("FAIL wrap_next_pc: want pc 1 after the instruction at 254 (%0d pcs seen)", got_pcs.size()); end
        vectors++; if (icnt !== 16'd4) begin miscompares++; $display("FAIL wrap_icnt: got %0d want 4", icnt); end
        vectors++; if (trace_diffs() != 0) begin miscompares++; $display("FAIL wrap_bus_trace: %0d entries differ", trace_diffs()); end
        vectors++; if (mem_diffs() != 0) begin miscompares++; $display("FAIL wrap_mem_image: %0d bytes differ", mem_diffs()); end
    endtask

    task automatic test_random();
        int n, bc, lk; logic [7:0] mpc; bit mh, sh, noisy;
        for (int t = 0; t < 12; t++) begin
            noisy = t[0];
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
            load_image();
            model_run(8'd1, 30, n, mpc, mh);
            start_run();
            run_core(mh ? 6 * n + 20 : 180, noisy, bc, lk, sh);
            rec_en = 1'b0;
            vectors++; if (sh != mh) begin miscompares++; $display("FAIL rnd%0d_halt: got %b want %b", t, sh, mh); end
            vectors++; if (bc != 6 * n) begin miscompares++; $display("FAIL rnd%0d_busy_cycles: got %0d want %0d", t, bc, 6 * n); end
            vectors++; if (pc !== mpc) begin miscompares++; $display("FAIL rnd%0d_pc: got %0d want %0d", t, pc, mpc); end
            vectors++; if (icnt !== 16'(n)) begin miscompares++; $display("FAIL rnd%0d_icnt: got %0d want %0d", t, icnt, n); end
            vectors++; if (lk != 0) begin miscompares++; $display("FAIL rnd%0d_gnt_while_busy: got %0d want 0", t, lk); end
            vectors++; if (mem_diffs() != 0) begin miscompares++; $display("FAIL rnd%0d_mem_image: %0d bytes differ", t, mem_diffs()); end
            vectors++; if (trace_diffs() != 0) begin miscompares++; $display("FAIL rnd%0d_bus_trace: %0d entries differ", t, trace_diffs()); end
            if (!mh) reset_dut();
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_host_branch();
        test_reset_mid();
        test_host_stall();
        test_start_host_halt();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
